wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-port arbiter for the register file, sitting after the MEM/WB pipeline register. Shares the single register-file write port between the in-order pipeline writeback and results from a long-latency auxiliary unit (multi-cycle mul/div). Aux results are queued in a small FIFO that drains on pipeline bubbles. A starvation counter stalls the pipeline for one cycle when the queue has waited too long.

## Interface
Parameters:
- DATA_W, 32, register data width
- REG_W, 5, register index width
- DEPTH, 2, aux FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive non-drained cycles before a forced drain (1..15)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- pipe_valid  input  1  MEM/WB stage holds a register write (RegWrite)
- pipe_rd  input  REG_W  destination of pipeline write
- pipe_data  input  DATA_W  writeback data (already MemtoReg-muxed)
- aux_valid  input  1  aux unit presents a result
- aux_ready  output  1  FIFO can accept; transfer when aux_valid && aux_ready
- aux_rd  input  REG_W  aux destination
- aux_data  input  DATA_W  aux result
- pipe_stall  output  1  hold MEM/WB contents this cycle
- rf_we  output  1  register file write enable (registered)
- rf_waddr  output  REG_W  register file write address (registered)
- rf_wdata  output  DATA_W  register file write data (registered)

## Operation
- Reset: FIFO empty, all entries invalid, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0. Consequently aux_ready=1 and pipe_stall=0.
- aux_ready = (count < DEPTH), computed from registered count only. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- Pipeline accepted = pipe_valid && !pipe_stall. Pipeline has priority. Grant goes to pipe if accepted, otherwise to the FIFO head if nonempty, otherwise idle.
- pipe_stall = fifo_nonempty && (starve_cnt == STARVE_MAX). It is a function of registered state only. While stalled, pipe inputs are ignored and the FIFO head is granted.
- Write to r0: any grant with rd==0 pops or consumes normally, but drives rf_we=0.
- WAW kill: aux results are defined older than any concurrent pipeline write. When the pipe is accepted with pipe_rd≠0:
  - every FIFO entry with rd==pipe_rd is invalidated;
  - an aux push in the same cycle with the same rd is stored invalidated.
- Killed entries still pop in FIFO order and drive rf_we=0.
- starve_cnt:
  - cleared on reset, on any pop, and whenever the FIFO is empty;
  - otherwise incremented, saturating at STARVE_MAX.
- Simultaneous push and pop on a nonempty, non-full FIFO: both occur and count is unchanged.
- A push into an empty FIFO is not bypassed; it is poppable from the next cycle.

## Timing
- Pipe write: pipe_valid sampled at edge E, so rf_we/rf_waddr/rf_wdata are valid in the cycle after E (latency 1).
- Aux write: handshake at edge E0; earliest pop at E1; rf_we visible after E1 (latency 2 minimum).
- Forced drain: the FIFO stays nonempty and un-popped for STARVE_MAX edges. pipe_stall is then high for exactly one cycle, the head pops at that edge, and the counter clears.
- Asynchronous reset mid-operation: FIFO contents are discarded and outputs return to reset values immediately. Queued aux results are lost, and the aux unit is flushed by the same reset.

## Configuration
- WB_ARB_STARVE_EN defined: the starvation counter and pipe_stall behave as above.
- Not defined:
  - counter logic is removed and pipe_stall is tied 0;
  - the FIFO drains only on cycles with pipe_valid=0;
  - aux_ready backpressure is the sole flow control.

## Test plan
- Reset, then pipe_valid=1, rd=5, data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. aux_ready=1 throughout.
- pipe idle; aux push rd=7, data=0x12 at E0 -> rf_we=1, rf_waddr=7 after E1; FIFO empty afterwards.
- pipe_valid held 1; push two aux results, then a third -> aux_ready=0 after the second push. With STARVE_MAX=4, pipe_stall=1 on the cycle after the 4th starved edge. Head pops, then pipe_stall=0.
- FIFO holds rd=9; pipe accepted with rd=9 -> pipe writes r9. The later pop of the r9 entry drives rf_we=0.
- pipe rd=0 and aux rd=0 results -> rf_we stays 0; the FIFO still drains.
- rst_n pulsed low with two entries queued -> outputs clear asynchronously, aux_ready=1, and no stale write after release. Repeat with WB_ARB_STARVE_EN undefined: pipe_stall never asserts.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs queued aux results.
// Optional WB_ARB_STARVE_EN adds a starvation counter that forces a FIFO drain.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_valid,
    input  logic [REG_W-1:0]  pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [REG_W-1:0]  aux_rd,
    input  logic [DATA_W-1:0] aux_data,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [REG_W-1:0]  q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_ok;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW:0]       count;

    logic nonempty;
    logic push;
    logic pop;
    logic pipe_acc;
    logic kill_en;

    assign nonempty  = (count != '0);
    assign aux_ready = (count < FULL);
    assign push      = aux_valid && aux_ready;
    assign pipe_acc  = pipe_valid && !pipe_stall;
    assign pop       = nonempty && !pipe_acc;
    assign kill_en   = pipe_acc && (pipe_rd != '0);

`ifdef WB_ARB_STARVE_EN
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;

    assign pipe_stall = nonempty && (starve_cnt == SMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!nonempty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign pipe_stall = 1'b0;
`endif

    // Payload needs no reset: q_ok and count gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= aux_rd;
            q_data[wr_ptr] <= aux_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ok   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Aux results are older than a concurrent pipe write: kill WAW.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && q_rd[i] == pipe_rd) begin
                    q_ok[i] <= 1'b0;
                end
            end
            if (push) begin
                q_ok[wr_ptr] <= !(kill_en && aux_rd == pipe_rd);
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (pipe_acc) begin
            rf_we    <= (pipe_rd != '0);
            rf_waddr <= pipe_rd;
            rf_wdata <= pipe_data;
        end else if (pop) begin
            rf_we    <= q_ok[rd_ptr] && (q_rd[rd_ptr] != '0);
            rf_waddr <= q_rd[rd_ptr];
            rf_wdata <= q_data[rd_ptr];
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model plus directed vectors.
// Builds with or without WB_ARB_STARVE_EN.
module tb_wb_arbiter;

    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int DEP  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pipe_valid = 1'b0;
    logic [RW-1:0] pipe_rd = '0;
    logic [DW-1:0] pipe_data = '0;
    logic          aux_valid = 1'b0;
    logic          aux_ready;
    logic [RW-1:0] aux_rd = '0;
    logic [DW-1:0] aux_data = '0;
    logic          pipe_stall;
    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(
        .DATA_W(DW), .REG_W(RW), .DEPTH(DEP), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_rd(aux_rd), .aux_data(aux_data),
        .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [DW-1:0] act,
                                logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, exp, $time);
        end
    endfunction

    // Reference model: a queue of pending aux results with a live flag.
    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    ent_t          q[$];
    int            sc = 0;
    bit            m_we = 0;
    logic [RW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    function automatic bit m_stall();
`ifdef WB_ARB_STARVE_EN
        return (q.size() > 0) && (sc == SMAX);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            sc = 0;
            m_we = 0;
            m_addr = '0;
            m_data = '0;
        end else begin
            int   n0;
            bit   acc;
            bit   psh;
            bit   popped;
            ent_t e;
            n0     = q.size();
            acc    = pipe_valid && !m_stall();
            psh    = aux_valid && (n0 < DEP);
            popped = 0;
            if (acc) begin
                m_we   = (pipe_rd != 0);
                m_addr = pipe_rd;
                m_data = pipe_data;
                if (pipe_rd != 0)
                    foreach (q[i]) if (q[i].rd == pipe_rd) q[i].live = 0;
            end else if (n0 > 0) begin
                e      = q.pop_front();
                m_we   = e.live && (e.rd != 0);
                m_addr = e.rd;
                m_data = e.d;
                popped = 1;
            end else begin
                m_we = 0;
            end
            if (n0 == 0 || popped) sc = 0;
            else if (sc < SMAX) sc = sc + 1;
            if (psh) begin
                e.rd   = aux_rd;
                e.d    = aux_data;
                e.live = !(acc && pipe_rd != 0 && aux_rd == pipe_rd);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("aux_ready", DW'(aux_ready), DW'(q.size() < DEP));
            chk("pipe_stall", DW'(pipe_stall), DW'(m_stall()));
            chk("rf_we", DW'(rf_we), DW'(m_we));
            if (m_we) begin
                chk("rf_waddr", DW'(rf_waddr), DW'(m_addr));
                chk("rf_wdata", rf_wdata, m_data);
            end
        end
    end

    task automatic cyc(input bit pv, input int prd, input logic [DW-1:0] pd,
                       input bit av, input int ard, input logic [DW-1:0] ad);
        pipe_valid = pv;
        pipe_rd    = RW'(prd);
        pipe_data  = pd;
        aux_valid  = av;
        aux_rd     = RW'(ard);
        aux_data   = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", DW'(rf_we), 0);
        chk("rst_waddr", DW'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_ready", DW'(aux_ready), 1);
        chk("rst_stall", DW'(pipe_stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0);
        chk("pipe_we", DW'(rf_we), 1);
        chk("pipe_waddr", DW'(rf_waddr), 5);
        chk("pipe_wdata", rf_wdata, 32'hDEADBEEF);
        idle(1);
        chk("pipe_we_off", DW'(rf_we), 0);

        cyc(0, 0, 0, 1, 7, 32'h12);
        chk("aux_lat1_we", DW'(rf_we), 0);
        idle(1);
        chk("aux_we", DW'(rf_we), 1);
        chk("aux_waddr", DW'(rf_waddr), 7);
        chk("aux_wdata", rf_wdata, 32'h12);
        idle(1);
        chk("aux_empty_ready", DW'(aux_ready), 1);

        cyc(1, 10, 32'hA0, 1, 11, 32'hB1);
        cyc(1, 12, 32'hA2, 1, 13, 32'hB3);
        chk("full_ready", DW'(aux_ready), 0);
        cyc(1, 14, 32'hA4, 1, 15, 32'hB5);
        cyc(1, 16, 32'hA6, 1, 15, 32'hB5);
        cyc(1, 17, 32'hA7, 1, 15, 32'hB5);
`ifdef WB_ARB_STARVE_EN
        chk("starve_stall", DW'(pipe_stall), 1);
        cyc(1, 18, 32'hA8, 0, 0, 0);
        chk("forced_we", DW'(rf_we), 1);
        chk("forced_waddr", DW'(rf_waddr), 11);
        chk("forced_wdata", rf_wdata, 32'hB1);
        chk("stall_clear", DW'(pipe_stall), 0);
        chk("forced_ready", DW'(aux_ready), 1);
        idle(1);
        chk("drain_waddr", DW'(rf_waddr), 13);
`else
        chk("nostarve_stall", DW'(pipe_stall), 0);
        chk("nostarve_waddr", DW'(rf_waddr), 17);
        cyc(1, 18, 32'hA8, 0, 0, 0);
        idle(1);
        chk("drain_waddr", DW'(rf_waddr), 11);
`endif
        idle(2);

        cyc(0, 0, 0, 1, 9, 32'h99);
        cyc(1, 9, 32'h55, 0, 0, 0);
        chk("waw_pipe_waddr", DW'(rf_waddr), 9);
        chk("waw_pipe_wdata", rf_wdata, 32'h55);
        idle(1);
        chk("waw_kill_we", DW'(rf_we), 0);
        cyc(1, 3, 32'h33, 1, 3, 32'h44);
        chk("waw_same_we", DW'(rf_we), 1);
        idle(1);
        chk("waw_same_kill", DW'(rf_we), 0);
        idle(1);

        cyc(1, 0, 32'h1, 0, 0, 0);
        chk("r0_pipe_we", DW'(rf_we), 0);
        cyc(0, 0, 0, 1, 0, 32'h2);
        idle(1);
        chk("r0_aux_we", DW'(rf_we), 0);
        idle(1);
        chk("r0_drained", DW'(aux_ready), 1);

        cyc(1, 20, 32'hC0, 1, 21, 32'hD1);
        cyc(1, 22, 32'hC2, 1, 23, 32'hD3);
        chk("prerst_ready", DW'(aux_ready), 0);
        chk("prerst_we", DW'(rf_we), 1);
        pipe_valid = 0;
        aux_valid  = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", DW'(rf_we), 0);
        chk("arst_waddr", DW'(rf_waddr), 0);
        chk("arst_wdata", rf_wdata, 0);
        chk("arst_ready", DW'(aux_ready), 1);
        chk("arst_stall", DW'(pipe_stall), 0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("post_rst_we", DW'(rf_we), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
